ctrl_pipe: RTL

Parametrised RV32I pipeline control unit for the five-stage core: decodes the instruction in Decode and carries a control bundle through E, M and W pipeline registers. Per-stage valid bits, a global memory stall, load-use hazard detection and E-stage forwarding selects are generated here. It replaces the earlier fixed 3-bit-ALU controller, with full RV32I ALU decode (shifts, SLTU), destination/source tags and illegal-instruction flagging.

---
 rtl/ctrl_pkg.sv | 71 +++++++
 rtl/ctrl_pipe_if.sv | 42 ++++
 rtl/ctrl_decode.sv | 123 ++++++++++++
 rtl/flopenrc.sv | 21 ++
 rtl/ctrl_pipe.sv | 99 +++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcode, ALU and immediate-format encodings plus the control bundle
// that travels down the E/M/W pipeline registers.
package ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    // rd/rs1/rs2 are zero whenever the instruction does not use that field.
    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
        logic       memen;
        logic       load_imm;
        logic       auipc;
        logic       alusrc;
        logic [3:0] alucontrol;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic       valid;
    } ctrl_t;

    // alt selects SUB for funct3 000 and SRA for funct3 101.
    function automatic logic [3:0] alu_arith(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic reg_hit(input logic vld, input logic rw,
                                     input logic [4:0] rd, input logic [4:0] rs);
        return vld & rw & (rd != 5'd0) & (rd == rs);
    endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// Decode-side inputs and per-stage control outputs of the pipeline controller.
interface ctrl_pipe_if #(parameter int ALUCTL_W = 4);

    logic [31:0]         instr_D;
    logic                valid_D;
    logic                flush_D;
    logic                mem_stall;
    logic                jump_D;
    logic                branch_D;
    logic [2:0]          sub_control_D;
    logic [2:0]          immcontrol_D;
    logic                stall_D;
    logic                illegal_D;
    logic                valid_E, valid_M, valid_W;
    logic                regwrite_E, regwrite_M, regwrite_W;
    logic                memtoreg_E, memtoreg_M, memtoreg_W;
    logic [4:0]          rd_E, rd_M, rd_W;
    logic                load_imm_E, auipc_E, alusrc_E;
    logic [ALUCTL_W-1:0] alucontrol_E;
    logic [1:0]          fwd_a_E, fwd_b_E;
    logic                memwrite_M, memen_M;
    logic [2:0]          mem_funct3_M;

    modport slave (
        input  instr_D, valid_D, flush_D, mem_stall,
        output jump_D, branch_D, sub_control_D, immcontrol_D, stall_D, illegal_D,
               valid_E, valid_M, valid_W, regwrite_E, regwrite_M, regwrite_W,
               memtoreg_E, memtoreg_M, memtoreg_W, rd_E, rd_M, rd_W,
               load_imm_E, auipc_E, alusrc_E, alucontrol_E, fwd_a_E, fwd_b_E,
               memwrite_M, memen_M, mem_funct3_M
    );

    modport master (
        output instr_D, valid_D, flush_D, mem_stall,
        input  jump_D, branch_D, sub_control_D, immcontrol_D, stall_D, illegal_D,
               valid_E, valid_M, valid_W, regwrite_E, regwrite_M, regwrite_W,
               memtoreg_E, memtoreg_M, memtoreg_W, rd_E, rd_M, rd_W,
               load_imm_E, auipc_E, alusrc_E, alucontrol_E, fwd_a_E, fwd_b_E,
               memwrite_M, memen_M, mem_funct3_M
    );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational RV32I decode: instruction word to control bundle, D-stage
// controls and illegal flag.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter bit RV32E = 1'b0
) (
    input  logic        valid_i,
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output logic        jump_o,
    output logic        branch_o,
    output logic [2:0]  immcontrol_o,
    output logic        illegal_o
);

    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;
    logic       ill, use_rd, use_rs1, use_rs2, jump, branch;
    ctrl_t      c;

    assign opc = instr_i[6:0];
    assign rd  = instr_i[11:7];
    assign f3  = instr_i[14:12];
    assign rs1 = instr_i[19:15];
    assign rs2 = instr_i[24:20];
    assign f7  = instr_i[31:25];

    always_comb begin
        c            = '0;
        c.alucontrol = ALU_ADD;
        c.funct3     = f3;
        ill          = 1'b0;
        use_rd       = 1'b0;
        use_rs1      = 1'b1;
        use_rs2      = 1'b0;
        jump         = 1'b0;
        branch       = 1'b0;
        immcontrol_o = IMM_I;
        case (opc)
            OPC_OP: begin
                use_rd     = 1'b1;
                use_rs2    = 1'b1;
                c.regwrite = 1'b1;
                if (f7 == F7_BASE)
                    c.alucontrol = alu_arith(f3, 1'b0);
                else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))
                    c.alucontrol = alu_arith(f3, 1'b1);
                else
                    ill = 1'b1;
            end
            OPC_IMM: begin
                use_rd     = 1'b1;
                c.regwrite = 1'b1;
                c.alusrc   = 1'b1;
                c.alucontrol = alu_arith(f3, f3 == 3'b101 && f7 == F7_ALT);
                // Shift immediates reuse the funct7 field; everything else is a plain immediate.
                if (f3 == 3'b001 && f7 != F7_BASE)
                    ill = 1'b1;
                if (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT)
                    ill = 1'b1;
            end
            OPC_LOAD: begin
                use_rd     = 1'b1;
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
                c.memen    = 1'b1;
                c.alusrc   = 1'b1;
            end
            OPC_STORE: begin
                use_rs2      = 1'b1;
                c.memwrite   = 1'b1;
                c.memen      = 1'b1;
                c.alusrc     = 1'b1;
                immcontrol_o = IMM_S;
            end
            OPC_BRANCH: begin
                use_rs2      = 1'b1;
                branch       = 1'b1;
                immcontrol_o = IMM_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                use_rd       = 1'b1;
                use_rs1      = 1'b0;
                c.regwrite   = 1'b1;
                c.load_imm   = 1'b1;
                c.auipc      = (opc == OPC_AUIPC);
                c.alusrc     = 1'b1;
                immcontrol_o = IMM_U;
            end
            OPC_JAL: begin
                use_rd       = 1'b1;
                use_rs1      = 1'b0;
                c.regwrite   = 1'b1;
                jump         = 1'b1;
                immcontrol_o = IMM_J;
            end
            OPC_JALR: begin
                use_rd     = 1'b1;
                c.regwrite = 1'b1;
                c.alusrc   = 1'b1;
                jump       = 1'b1;
            end
            default: begin
                ill     = 1'b1;
                use_rs1 = 1'b0;
            end
        endcase
        if (RV32E && ((use_rd & rd[4]) | (use_rs1 & rs1[4]) | (use_rs2 & rs2[4])))
            ill = 1'b1;
        c.rd    = use_rd  ? rd  : 5'd0;
        c.rs1   = use_rs1 ? rs1 : 5'd0;
        c.rs2   = use_rs2 ? rs2 : 5'd0;
        c.valid = valid_i & ~ill;
    end

    assign ctrl_o    = c;
    assign illegal_o = valid_i & ill;
    assign jump_o    = valid_i & jump;
    assign branch_o  = valid_i & branch;

endmodule

// File: rtl/flopenrc.sv
// Enabled pipeline register with synchronous reset and synchronous clear.
module flopenrc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    // Clear only takes effect on an enabled edge, so a frozen stage keeps its contents.
    always_ff @(posedge clk) begin
        if (rst)
            q_o <= '0;
        else if (en_i)
            q_o <= clr_i ? '0 : d_i;
    end

endmodule

// File: rtl/ctrl_pipe.sv
// RV32I pipeline controller: decode, E/M/W control registers, hazard stall and
// forwarding selects. Define CTRL_FWD_EN to enable E-stage forwarding.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int ALUCTL_W = 4,
    parameter bit RV32E    = 1'b0
) (
    input logic        clk,
    input logic        rst,
    ctrl_pipe_if.slave bus
);

    ctrl_t dec, e_d, e_q, m_q, w_q;
    logic  en, clr_e, stall;
    logic  unused_bits;

    ctrl_decode #(.RV32E(RV32E)) u_dec (
        .valid_i      (bus.valid_D),
        .instr_i      (bus.instr_D),
        .ctrl_o       (dec),
        .jump_o       (bus.jump_D),
        .branch_o     (bus.branch_D),
        .immcontrol_o (bus.immcontrol_D),
        .illegal_o    (bus.illegal_D)
    );

`ifdef CTRL_FWD_EN
    // Only a load still in E cannot be forwarded in time.
    assign stall = bus.valid_D & e_q.memtoreg &
                   (reg_hit(e_q.valid, e_q.regwrite, e_q.rd, dec.rs1) |
                    reg_hit(e_q.valid, e_q.regwrite, e_q.rd, dec.rs2));

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (reg_hit(m_q.valid, m_q.regwrite, m_q.rd, rs))
            return 2'b01;
        else if (reg_hit(w_q.valid, w_q.regwrite, w_q.rd, rs))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign bus.fwd_a_E = fwd_sel(e_q.rs1);
    assign bus.fwd_b_E = fwd_sel(e_q.rs2);
`else
    // Without forwarding, wait until producers leave M; W is covered by write-first.
    assign stall = bus.valid_D &
                   (reg_hit(e_q.valid, e_q.regwrite, e_q.rd, dec.rs1) |
                    reg_hit(e_q.valid, e_q.regwrite, e_q.rd, dec.rs2) |
                    reg_hit(m_q.valid, m_q.regwrite, m_q.rd, dec.rs1) |
                    reg_hit(m_q.valid, m_q.regwrite, m_q.rd, dec.rs2));

    assign bus.fwd_a_E = 2'b00;
    assign bus.fwd_b_E = 2'b00;
`endif

    assign bus.stall_D       = stall;
    assign bus.sub_control_D = bus.instr_D[14:12];

    assign en    = ~bus.mem_stall;
    assign clr_e = bus.flush_D | stall;
    assign e_d   = dec.valid ? dec : '0;

    flopenrc #(.WIDTH($bits(ctrl_t))) u_reg_e (
        .clk(clk), .rst(rst), .en_i(en), .clr_i(clr_e), .d_i(e_d), .q_o(e_q)
    );
    flopenrc #(.WIDTH($bits(ctrl_t))) u_reg_m (
        .clk(clk), .rst(rst), .en_i(en), .clr_i(1'b0), .d_i(e_q), .q_o(m_q)
    );
    flopenrc #(.WIDTH($bits(ctrl_t))) u_reg_w (
        .clk(clk), .rst(rst), .en_i(en), .clr_i(1'b0), .d_i(m_q), .q_o(w_q)
    );

    assign bus.valid_E      = e_q.valid;
    assign bus.regwrite_E   = e_q.regwrite;
    assign bus.memtoreg_E   = e_q.memtoreg;
    assign bus.rd_E         = e_q.rd;
    assign bus.load_imm_E   = e_q.load_imm;
    assign bus.auipc_E      = e_q.auipc;
    assign bus.alusrc_E     = e_q.alusrc;
    assign bus.alucontrol_E = ALUCTL_W'(e_q.alucontrol);

    assign bus.valid_M      = m_q.valid;
    assign bus.regwrite_M   = m_q.regwrite;
    assign bus.memtoreg_M   = m_q.memtoreg;
    assign bus.rd_M         = m_q.rd;
    assign bus.memwrite_M   = m_q.memwrite;
    assign bus.memen_M      = m_q.memen;
    assign bus.mem_funct3_M = m_q.funct3;

    assign bus.valid_W      = w_q.valid;
    assign bus.regwrite_W   = w_q.regwrite;
    assign bus.memtoreg_W   = w_q.memtoreg;
    assign bus.rd_W         = w_q.rd;

    // Later stages carry the full bundle; fields they do not drive out are folded here.
    assign unused_bits = ^{e_q, m_q, w_q};

endmodule
